cam_ctrl: RTL and testbench

- Sequencing controller in front of the 32-entry x 32-bit `cam` block.
- Turns single-request LOOKUP / INSERT / DELETE operations (ready/valid handshake) into CAM search and write cycles.
- Owns the occupancy bitmap and free-entry allocation, so CAM entries stay unique.
- Sits between the client logic and the `cam` instance; `cam` reset is tied to the same reset_i.

---
 rtl/cam_ctrl.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// -----------------------------------------------------------------------------
// cam_ctrl
//
// Sequencing controller in front of a 32-entry x 32-bit CAM. Accepts one
// LOOKUP / INSERT / DELETE request at a time over a ready/valid handshake.
// Each request becomes a CAM search, optionally followed by a CAM write.
// The controller owns the occupancy bitmap and the free-entry allocator, so
// every key lives in at most one CAM entry.
//
// CAM word layout: {tag, key}. The MSB is the entry-valid tag. A freed entry
// is written with all zeros, so its tag is 0 and a search word, whose tag is
// always 1, can never match it.
//
// Ports
//   clk, reset_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     request handshake
//   req_op_i                00 LOOKUP, 01 INSERT, 10 DELETE, 11 reserved
//   req_key_i               key
//   resp_valid_o/ready_i    response handshake
//   resp_hit_o              key was present before the operation
//   resp_index_o            entry index that was hit, allocated or freed
//   resp_full_o             INSERT missed and no entry was free
//   resp_err_o              reserved opcode
//   count_o                 number of live entries
//   cam_search_o/_data_o    CAM search strobe and search word
//   cam_search_valid_i/_index_i  CAM hit, valid the cycle after the strobe
//   cam_write_o/_index_o/_data_o CAM write strobe, index and word
//
// Optional build macro CAM_CTRL_STATS_EN adds the 16-bit saturating counters
// stat_hit_o, stat_miss_o and stat_full_o. They step on the response
// handshake edge.
// -----------------------------------------------------------------------------
module cam_ctrl #(
    parameter int ARRAY_WIDTH_LOG2 = 5,
    parameter int ARRAY_SIZE_LOG2  = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [1:0]                         req_op_i,
    input  logic [2**ARRAY_WIDTH_LOG2-2:0]     req_key_i,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic                               resp_hit_o,
    output logic [ARRAY_SIZE_LOG2-1:0]         resp_index_o,
    output logic                               resp_full_o,
    output logic                               resp_err_o,
    output logic [ARRAY_SIZE_LOG2:0]           count_o,
    output logic                               cam_search_o,
    output logic [2**ARRAY_WIDTH_LOG2-1:0]     cam_search_data_o,
    input  logic                               cam_search_valid_i,
    input  logic [ARRAY_WIDTH_LOG2-1:0]        cam_search_index_i,
    output logic                               cam_write_o,
    output logic [ARRAY_WIDTH_LOG2-1:0]        cam_write_index_o,
    output logic [2**ARRAY_WIDTH_LOG2-1:0]     cam_write_data_o
`ifdef CAM_CTRL_STATS_EN
    ,
    output logic [15:0]                        stat_hit_o,
    output logic [15:0]                        stat_miss_o,
    output logic [15:0]                        stat_full_o
`endif
);

    localparam int W  = 2**ARRAY_WIDTH_LOG2;   // CAM word width
    localparam int KW = W - 1;                 // key width
    localparam int N  = 2**ARRAY_SIZE_LOG2;    // entry count
    localparam int IW = ARRAY_SIZE_LOG2;       // entry index width
    localparam int AW = ARRAY_WIDTH_LOG2;      // CAM-side index port width
    localparam int CW = ARRAY_SIZE_LOG2 + 1;   // live-entry count width

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t          state_reg;
    logic [1:0]      op_reg;
    logic [KW-1:0]   key_reg;
    logic [N-1:0]    bitmap_reg;
    logic [CW-1:0]   count_reg;

    logic            req_ready_reg;
    logic            resp_valid_reg;
    logic            resp_hit_reg;
    logic [IW-1:0]   resp_index_reg;
    logic            resp_full_reg;
    logic            resp_err_reg;

    logic            cam_search_reg;
    logic            cam_write_reg;
    logic [IW-1:0]   cam_write_index_reg;
    logic [W-1:0]    cam_write_data_reg;

    // Search result, qualified by the bitmap: a CAM match on an entry the
    // bitmap considers free is not trusted and counts as a miss.
    logic [IW-1:0]   hit_idx;
    logic            search_hit;
    logic            is_full;

    assign hit_idx    = IW'(cam_search_index_i);
    assign search_hit = cam_search_valid_i && bitmap_reg[hit_idx];
    assign is_full    = (count_reg == CW'(N));

    // Lowest-index free entry. Scanning from the top down lets the last
    // assignment, which is the lowest free index, win.
    logic [IW-1:0]   free_idx;

    always_comb begin
        free_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!bitmap_reg[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_reg           <= ST_IDLE;
            op_reg              <= OP_LOOKUP;
            key_reg             <= '0;
            bitmap_reg          <= '0;
            count_reg           <= '0;
            req_ready_reg       <= 1'b1;
            resp_valid_reg      <= 1'b0;
            resp_hit_reg        <= 1'b0;
            resp_index_reg      <= '0;
            resp_full_reg       <= 1'b0;
            resp_err_reg        <= 1'b0;
            cam_search_reg      <= 1'b0;
            cam_write_reg       <= 1'b0;
            cam_write_index_reg <= '0;
            cam_write_data_reg  <= '0;
        end else begin
            // CAM strobes are single-cycle pulses.
            cam_search_reg <= 1'b0;
            cam_write_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        op_reg        <= req_op_i;
                        key_reg       <= req_key_i;
                        req_ready_reg <= 1'b0;
                        if (req_op_i == OP_RSVD) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_hit_reg   <= 1'b0;
                            resp_full_reg  <= 1'b0;
                            resp_index_reg <= '0;
                        end else begin
                            state_reg      <= ST_SEARCH;
                            cam_search_reg <= 1'b1;
                        end
                    end
                end

                ST_SEARCH: begin
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Response fields are loaded here. resp_valid_o rises
                    // either now or after the WRITE cycle.
                    resp_err_reg  <= 1'b0;
                    resp_full_reg <= 1'b0;
                    case (op_reg)
                        OP_INSERT: begin
                            if (search_hit) begin
                                state_reg      <= ST_RESP;
                                resp_valid_reg <= 1'b1;
                                resp_hit_reg   <= 1'b1;
                                resp_index_reg <= hit_idx;
                            end else if (is_full) begin
                                state_reg      <= ST_RESP;
                                resp_valid_reg <= 1'b1;
                                resp_hit_reg   <= 1'b0;
                                resp_full_reg  <= 1'b1;
                                resp_index_reg <= '0;
                            end else begin
                                state_reg            <= ST_WRITE;
                                cam_write_reg        <= 1'b1;
                                cam_write_index_reg  <= free_idx;
                                cam_write_data_reg   <= {1'b1, key_reg};
                                bitmap_reg[free_idx] <= 1'b1;
                                count_reg            <= count_reg + 1'b1;
                                resp_hit_reg         <= 1'b0;
                                resp_index_reg       <= free_idx;
                            end
                        end
                        OP_DELETE: begin
                            if (search_hit) begin
                                state_reg           <= ST_WRITE;
                                cam_write_reg       <= 1'b1;
                                cam_write_index_reg <= hit_idx;
                                cam_write_data_reg  <= '0;
                                bitmap_reg[hit_idx] <= 1'b0;
                                count_reg           <= count_reg - 1'b1;
                                resp_hit_reg        <= 1'b1;
                                resp_index_reg      <= hit_idx;
                            end else begin
                                state_reg      <= ST_RESP;
                                resp_valid_reg <= 1'b1;
                                resp_hit_reg   <= 1'b0;
                                resp_index_reg <= '0;
                            end
                        end
                        default: begin
                            // LOOKUP (reserved opcodes never reach WAIT)
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_hit_reg   <= search_hit;
                            resp_index_reg <= search_hit ? hit_idx : '0;
                        end
                    endcase
                end

                ST_WRITE: begin
                    state_reg      <= ST_RESP;
                    resp_valid_reg <= 1'b1;
                end

                ST_RESP: begin
                    // Fields hold until the client takes the response.
                    if (resp_ready_i) begin
                        state_reg      <= ST_IDLE;
                        req_ready_reg  <= 1'b1;
                        resp_valid_reg <= 1'b0;
                        resp_hit_reg   <= 1'b0;
                        resp_index_reg <= '0;
                        resp_full_reg  <= 1'b0;
                        resp_err_reg   <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = req_ready_reg;
    assign resp_valid_o      = resp_valid_reg;
    assign resp_hit_o        = resp_hit_reg;
    assign resp_index_o      = resp_index_reg;
    assign resp_full_o       = resp_full_reg;
    assign resp_err_o        = resp_err_reg;
    assign count_o           = count_reg;
    assign cam_search_o      = cam_search_reg;
    assign cam_search_data_o = {1'b1, key_reg};
    assign cam_write_o       = cam_write_reg;
    assign cam_write_index_o = AW'(cam_write_index_reg);
    assign cam_write_data_o  = cam_write_data_reg;

`ifdef CAM_CTRL_STATS_EN
    logic [15:0] stat_hit_reg;
    logic [15:0] stat_miss_reg;
    logic [15:0] stat_full_reg;
    logic        resp_done;
    logic        counted_op;

    assign resp_done  = (state_reg == ST_RESP) && resp_ready_i;
    assign counted_op = (op_reg == OP_LOOKUP) || (op_reg == OP_INSERT);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_hit_reg  <= '0;
            stat_miss_reg <= '0;
            stat_full_reg <= '0;
        end else if (resp_done && counted_op) begin
            if (resp_hit_reg) begin
                if (stat_hit_reg != 16'hFFFF) stat_hit_reg <= stat_hit_reg + 16'd1;
            end else begin
                if (stat_miss_reg != 16'hFFFF) stat_miss_reg <= stat_miss_reg + 16'd1;
            end
            if (resp_full_reg && (stat_full_reg != 16'hFFFF)) begin
                stat_full_reg <= stat_full_reg + 16'd1;
            end
        end
    end

    assign stat_hit_o  = stat_hit_reg;
    assign stat_miss_o = stat_miss_reg;
    assign stat_full_o = stat_full_reg;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_ctrl
//
// Directed bench for cam_ctrl. A small behavioural CAM answers searches one
// cycle after the strobe and applies writes. Expected values are hand-derived
// constants. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cam_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [30:0] req_key = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [4:0]  resp_index;
    logic        resp_full;
    logic        resp_err;
    logic [5:0]  count;
    logic        cam_search;
    logic [31:0] cam_search_data;
    logic        cam_search_valid;
    logic [4:0]  cam_search_index;
    logic        cam_write;
    logic [4:0]  cam_write_index;
    logic [31:0] cam_write_data;

    always #5 clk = ~clk;

    cam_ctrl dut (
        .clk                (clk),
        .reset_i            (reset_i),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_op_i           (req_op),
        .req_key_i          (req_key),
        .resp_valid_o       (resp_valid),
        .resp_ready_i       (resp_ready),
        .resp_hit_o         (resp_hit),
        .resp_index_o       (resp_index),
        .resp_full_o        (resp_full),
        .resp_err_o         (resp_err),
        .count_o            (count),
        .cam_search_o       (cam_search),
        .cam_search_data_o  (cam_search_data),
        .cam_search_valid_i (cam_search_valid),
        .cam_search_index_i (cam_search_index),
        .cam_write_o        (cam_write),
        .cam_write_index_o  (cam_write_index),
        .cam_write_data_o   (cam_write_data)
    );

    // Behavioural CAM: registered search result, reset clears every entry.
    logic [31:0] cam_mem [32];
    int          wr_cnt = 0;
    logic [4:0]  last_wr_idx = '0;
    logic [31:0] last_wr_data = '0;

    always @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) cam_mem[i] <= '0;
            cam_search_valid <= 1'b0;
            cam_search_index <= '0;
        end else begin
            cam_search_valid <= 1'b0;
            cam_search_index <= '0;
            if (cam_search) begin
                for (int i = 31; i >= 0; i--) begin
                    if (cam_mem[i] == cam_search_data) begin
                        cam_search_valid <= 1'b1;
                        cam_search_index <= 5'(i);
                    end
                end
            end
            if (cam_write) begin
                cam_mem[cam_write_index] <= cam_write_data;
                wr_cnt       <= wr_cnt + 1;
                last_wr_idx  <= cam_write_index;
                last_wr_data <= cam_write_data;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full request/response transaction. lat counts falling edges from
    // the accept edge up to the first one where resp_valid is seen high.
    task automatic do_op(input logic [1:0] op, input logic [30:0] key,
                         output int lat, output logic hit, output logic [4:0] idx,
                         output logic full, output logic err);
        int t;
        t = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("ready_timeout", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) check("resp_timeout", {63'd0, resp_valid}, 64'd1);
        hit  = resp_hit;
        idx  = resp_index;
        full = resp_full;
        err  = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        $display("op=%0d key=%0h lat=%0d hit=%0b idx=%0d full=%0b err=%0b count=%0d",
                 op, key, lat, hit, idx, full, err, count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic       hit, full, err;
        logic [4:0] idx;
        int         w0;

        // ---------------- reset state
        do_reset();
        @(negedge clk);
        check("rst_ready",  {63'd0, req_ready},  64'd1);
        check("rst_rvalid", {63'd0, resp_valid}, 64'd0);
        check("rst_count",  {58'd0, count},      64'd0);
        check("rst_search", {63'd0, cam_search}, 64'd0);
        check("rst_write",  {63'd0, cam_write},  64'd0);
        check("rst_hit",    {63'd0, resp_hit},   64'd0);

        // ---------------- first INSERT
        do_op(2'b01, 31'h1, lat, hit, idx, full, err);
        check("ins1_lat",   64'(lat),            64'd4);
        check("ins1_hit",   {63'd0, hit},        64'd0);
        check("ins1_idx",   {59'd0, idx},        64'd0);
        check("ins1_count", {58'd0, count},      64'd1);
        check("ins1_wridx", {59'd0, last_wr_idx}, 64'd0);
        check("ins1_wrdat", {32'd0, last_wr_data}, 64'h8000_0001);
        check("ins1_wrcnt", 64'(wr_cnt),         64'd1);

        // ---------------- duplicate INSERT and LOOKUP
        w0 = wr_cnt;
        do_op(2'b01, 31'h1, lat, hit, idx, full, err);
        check("ins2_lat",   64'(lat),       64'd3);
        check("ins2_hit",   {63'd0, hit},   64'd1);
        check("ins2_idx",   {59'd0, idx},   64'd0);
        do_op(2'b00, 31'h1, lat, hit, idx, full, err);
        check("lk1_lat",    64'(lat),       64'd3);
        check("lk1_hit",    {63'd0, hit},   64'd1);
        check("lk1_idx",    {59'd0, idx},   64'd0);
        check("dup_nowr",   64'(wr_cnt),    64'(w0));
        check("dup_count",  {58'd0, count}, 64'd1);

        // ---------------- fill from empty, then INSERT into a full CAM
        do_reset();
        for (int k = 0; k < 32; k++) begin
            do_op(2'b01, 31'(32'h10 + k), lat, hit, idx, full, err);
            check("fill_idx", {59'd0, idx}, 64'(k));
        end
        check("fill_count", {58'd0, count}, 64'd32);
        w0 = wr_cnt;
        do_op(2'b01, 31'h99, lat, hit, idx, full, err);
        check("full_flag",  {63'd0, full},  64'd1);
        check("full_hit",   {63'd0, hit},   64'd0);
        check("full_idx",   {59'd0, idx},   64'd0);
        check("full_lat",   64'(lat),       64'd3);
        check("full_nowr",  64'(wr_cnt),    64'(w0));
        check("full_count", {58'd0, count}, 64'd32);

        // ---------------- DELETE index 5, reuse it
        do_op(2'b10, 31'h15, lat, hit, idx, full, err);
        check("del_lat",    64'(lat),       64'd4);
        check("del_hit",    {63'd0, hit},   64'd1);
        check("del_idx",    {59'd0, idx},   64'd5);
        check("del_count",  {58'd0, count}, 64'd31);
        check("del_wrdat",  {32'd0, last_wr_data}, 64'd0);
        check("del_wridx",  {59'd0, last_wr_idx},  64'd5);
        do_op(2'b01, 31'h77, lat, hit, idx, full, err);
        check("reuse_idx",  {59'd0, idx},   64'd5);
        check("reuse_hit",  {63'd0, hit},   64'd0);
        check("reuse_cnt",  {58'd0, count}, 64'd32);
        do_op(2'b00, 31'h15, lat, hit, idx, full, err);
        check("old_miss",   {63'd0, hit},   64'd0);
        check("old_idx",    {59'd0, idx},   64'd0);
        do_op(2'b10, 31'h12345, lat, hit, idx, full, err);
        check("delmiss_hit", {63'd0, hit},  64'd0);
        check("delmiss_lat", 64'(lat),     64'd3);
        check("delmiss_cnt", {58'd0, count}, 64'd32);

        // ---------------- response back-pressure with a queued request
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_key   = 31'h77;
        check("bp_ready0", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_key = 31'h16;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("bp_lat", 64'(lat), 64'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_hit",   {63'd0, resp_hit},   64'd1);
            check("bp_idx",   {59'd0, resp_index}, 64'd5);
            check("bp_ready", {63'd0, req_ready},  64'd0);
        end
        $display("op=0 key=77 held for 5 cycles idx=%0d", resp_index);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("bp_idle_rdy", {63'd0, req_ready},  64'd1);
        check("bp_idle_rv",  {63'd0, resp_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("bp2_lat", 64'(lat),            64'd3);
        check("bp2_hit", {63'd0, resp_hit},   64'd1);
        check("bp2_idx", {59'd0, resp_index}, 64'd6);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        $display("op=0 key=16 lat=%0d queued request", lat);

        // ---------------- reserved opcode
        do_op(2'b11, 31'h5, lat, hit, idx, full, err);
        check("rsvd_lat", 64'(lat),     64'd1);
        check("rsvd_err", {63'd0, err}, 64'd1);
        check("rsvd_hit", {63'd0, hit}, 64'd0);

        // ---------------- reset during the WRITE of an INSERT
        do_op(2'b10, 31'h17, lat, hit, idx, full, err);
        check("del7_idx", {59'd0, idx}, 64'd7);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_key   = 31'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rw_search",  {63'd0, cam_search},      64'd1);
        check("rw_sdata",   {32'd0, cam_search_data}, 64'h8000_0055);
        @(negedge clk);
        @(negedge clk);
        check("rw_write",   {63'd0, cam_write},       64'd1);
        check("rw_wridx",   {59'd0, cam_write_index}, 64'd7);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("rw_rvalid",  {63'd0, resp_valid}, 64'd0);
        check("rw_ready",   {63'd0, req_ready},  64'd1);
        check("rw_count",   {58'd0, count},      64'd0);
        $display("reset during write of key 55");
        repeat (3) @(negedge clk);
        check("rw_noresp",  {63'd0, resp_valid}, 64'd0);
        do_op(2'b00, 31'h55, lat, hit, idx, full, err);
        check("rw_lk_hit",  {63'd0, hit},        64'd0);
        check("rw_lk_lat",  64'(lat),            64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
